// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the processor datapath.
//
// A state register on the falling edge of clk steps through the three fetch states and the
// per-instruction execute steps T3-T7. The outputs are decoded from the next state and
// registered on the same falling edge. The datapath then samples stable strobes on the
// following rising edge.
//
// Ports:
//   clk, reset (async, active-low)  clock and reset
//   IR[31:0]                        instruction register; the opcode is IR[31:27]
//   Branch                          CON flip-flop result, used only in T6 of br
//   *out                            bus drive strobes (at most one high per state)
//   *in                             register load strobes
//   GRA/GRB/GRC                     register-field selects
//   IncPc, read, write              PC increment and memory strobes
//   mdr_read[1:0]                   MDR source: 00 bus, 01 memory, 10 immediate
//   control[3:0]                    ALU op code, 0 when the ALU is idle
//   run                             high unless halted or held in reset
//   illegal                         one-state pulse in T3 for an unsupported opcode
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        Branch,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        Zlowin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Rin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        GRA,
    output logic        GRB,
    output logic        GRC,
    output logic        IncPc,
    output logic        read,
    output logic        write,
    output logic [1:0]  mdr_read,
    output logic [3:0]  control,
    output logic        run,
    output logic        illegal
);

    // StIdle is the state that reset holds: it looks like FETCH0 but every output is 0.
    typedef enum logic [3:0] {
        StIdle, StFetch0, StFetch1, StFetch2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu3, ClsAluImm, ClsLdi, ClsLd, ClsSt, ClsBr, ClsJr, ClsIn, ClsOut,
        ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
    } cls_e;

    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       ba_out;
        logic       r_out;
        logic       mar_in;
        logic       zlow_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       r_in;
        logic       outport_in;
        logic       con_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       inc_pc;
        logic       rd;
        logic       wr;
        logic [1:0] mdr_sel;
        logic [3:0] alu_op;
        logic       run;
        logic       illegal;
    } ctrl_t;

    localparam logic [3:0] AluAdd = 4'd2;
    localparam logic [3:0] AluSub = 4'd3;
    localparam logic [3:0] AluShr = 4'd4;
    localparam logic [3:0] AluShl = 4'd5;
    localparam logic [3:0] AluRor = 4'd6;
    localparam logic [3:0] AluRol = 4'd7;
    localparam logic [3:0] AluAnd = 4'd8;
    localparam logic [3:0] AluOr  = 4'd9;

    localparam logic [1:0] MdrBus = 2'b00;
    localparam logic [1:0] MdrMem = 2'b01;

    state_e     state_q, state_d;
    ctrl_t      out_q, out_d;
    cls_e       cls;
    logic [3:0] alu_code;
    logic [4:0] opcode;

    // Register fields are decoded in the datapath; only the opcode matters here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    assign opcode = IR[31:27];

    // Opcode to instruction class and ALU operation.
    always_comb begin
        cls      = ClsIllegal;
        alu_code = 4'd0;
        case (opcode)
            5'b00000: begin cls = ClsLd;     alu_code = AluAdd; end
            5'b00001: begin cls = ClsLdi;    alu_code = AluAdd; end
            5'b00010: begin cls = ClsSt;     alu_code = AluAdd; end
            5'b00011: begin cls = ClsAlu3;   alu_code = AluAdd; end
            5'b00100: begin cls = ClsAlu3;   alu_code = AluSub; end
            5'b00101: begin cls = ClsAlu3;   alu_code = AluShr; end
            5'b00110: begin cls = ClsAlu3;   alu_code = AluShl; end
            5'b00111: begin cls = ClsAlu3;   alu_code = AluRor; end
            5'b01000: begin cls = ClsAlu3;   alu_code = AluRol; end
            5'b01001: begin cls = ClsAlu3;   alu_code = AluAnd; end
            5'b01010: begin cls = ClsAlu3;   alu_code = AluOr;  end
            5'b01011: begin cls = ClsAluImm; alu_code = AluAdd; end
            5'b01100: begin cls = ClsAluImm; alu_code = AluAnd; end
            5'b01101: begin cls = ClsAluImm; alu_code = AluOr;  end
            5'b10010: begin cls = ClsBr;     alu_code = AluAdd; end
            5'b10011: cls = ClsJr;
            5'b10101: cls = ClsIn;
            5'b10110: cls = ClsOut;
            5'b10111: cls = ClsMfhi;
            5'b11000: cls = ClsMflo;
            5'b11001: cls = ClsNop;
            5'b11010: cls = ClsHalt;
            default:  cls = ClsIllegal;
        endcase
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch0;
            StFetch0: state_d = StFetch1;
            StFetch1: state_d = StFetch2;
            StFetch2: state_d = StT3;
            StT3: begin
                case (cls)
                    ClsHalt: state_d = StHalt;
                    ClsAlu3, ClsAluImm, ClsLdi, ClsLd, ClsSt, ClsBr: state_d = StT4;
                    default: state_d = StFetch0;
                endcase
            end
            StT4:     state_d = StT5;
            StT5:     state_d = (cls == ClsLd || cls == ClsSt || cls == ClsBr) ? StT6 : StFetch0;
            StT6:     state_d = (cls == ClsBr) ? StFetch0 : StT7;
            StT7:     state_d = StFetch0;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode for the state being entered; registered alongside the state.
    always_comb begin
        out_d     = '0;
        out_d.run = (state_d != StHalt) && (state_d != StIdle);
        case (state_d)
            StFetch0: begin
                out_d.pc_out  = 1'b1;
                out_d.mar_in  = 1'b1;
                out_d.inc_pc  = 1'b1;
                out_d.zlow_in = 1'b1;
            end
            StFetch1: begin
                out_d.zlow_out = 1'b1;
                out_d.pc_in    = 1'b1;
                out_d.rd       = 1'b1;
                out_d.mdr_sel  = MdrMem;
                out_d.mdr_in   = 1'b1;
            end
            StFetch2: begin
                out_d.mdr_out = 1'b1;
                out_d.ir_in   = 1'b1;
            end
            StT3: begin
                case (cls)
                    ClsAlu3, ClsAluImm: begin
                        out_d.grb   = 1'b1;
                        out_d.r_out = 1'b1;
                        out_d.y_in  = 1'b1;
                    end
                    ClsLdi, ClsLd, ClsSt: begin
                        out_d.grb    = 1'b1;
                        out_d.ba_out = 1'b1;
                        out_d.y_in   = 1'b1;
                    end
                    ClsBr: begin
                        out_d.gra    = 1'b1;
                        out_d.r_out  = 1'b1;
                        out_d.con_in = 1'b1;
                    end
                    ClsJr: begin
                        out_d.gra   = 1'b1;
                        out_d.r_out = 1'b1;
                        out_d.pc_in = 1'b1;
                    end
                    ClsIn: begin
                        out_d.inport_out = 1'b1;
                        out_d.gra        = 1'b1;
                        out_d.r_in       = 1'b1;
                    end
                    ClsOut: begin
                        out_d.gra        = 1'b1;
                        out_d.r_out      = 1'b1;
                        out_d.outport_in = 1'b1;
                    end
                    ClsMfhi: begin
                        out_d.hi_out = 1'b1;
                        out_d.gra    = 1'b1;
                        out_d.r_in   = 1'b1;
                    end
                    ClsMflo: begin
                        out_d.lo_out = 1'b1;
                        out_d.gra    = 1'b1;
                        out_d.r_in   = 1'b1;
                    end
                    ClsIllegal: out_d.illegal = 1'b1;
                    default: ;
                endcase
            end
            StT4: begin
                case (cls)
                    ClsAlu3: begin
                        out_d.grc     = 1'b1;
                        out_d.r_out   = 1'b1;
                        out_d.alu_op  = alu_code;
                        out_d.zlow_in = 1'b1;
                    end
                    ClsAluImm, ClsLdi, ClsLd, ClsSt: begin
                        out_d.c_out   = 1'b1;
                        out_d.alu_op  = alu_code;
                        out_d.zlow_in = 1'b1;
                    end
                    ClsBr: begin
                        out_d.pc_out = 1'b1;
                        out_d.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                case (cls)
                    ClsAlu3, ClsAluImm, ClsLdi: begin
                        out_d.zlow_out = 1'b1;
                        out_d.gra      = 1'b1;
                        out_d.r_in     = 1'b1;
                    end
                    ClsLd, ClsSt: begin
                        out_d.zlow_out = 1'b1;
                        out_d.mar_in   = 1'b1;
                    end
                    ClsBr: begin
                        out_d.c_out   = 1'b1;
                        out_d.alu_op  = AluAdd;
                        out_d.zlow_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                case (cls)
                    ClsLd: begin
                        out_d.rd      = 1'b1;
                        out_d.mdr_sel = MdrMem;
                        out_d.mdr_in  = 1'b1;
                    end
                    ClsSt: begin
                        out_d.gra     = 1'b1;
                        out_d.r_out   = 1'b1;
                        out_d.mdr_sel = MdrBus;
                        out_d.mdr_in  = 1'b1;
                    end
                    ClsBr: begin
                        // Taken branch loads the target computed in T5.
                        out_d.zlow_out = Branch;
                        out_d.pc_in    = Branch;
                    end
                    default: ;
                endcase
            end
            StT7: begin
                case (cls)
                    ClsLd: begin
                        out_d.mdr_out = 1'b1;
                        out_d.gra     = 1'b1;
                        out_d.r_in    = 1'b1;
                    end
                    ClsSt: out_d.wr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign PCout     = out_q.pc_out;
    assign Zlowout   = out_q.zlow_out;
    assign MDRout    = out_q.mdr_out;
    assign HIout     = out_q.hi_out;
    assign LOout     = out_q.lo_out;
    assign InPortout = out_q.inport_out;
    assign Cout      = out_q.c_out;
    assign BAout     = out_q.ba_out;
    assign Rout      = out_q.r_out;
    assign MARin     = out_q.mar_in;
    assign Zlowin    = out_q.zlow_in;
    assign PCin      = out_q.pc_in;
    assign MDRin     = out_q.mdr_in;
    assign IRin      = out_q.ir_in;
    assign Yin       = out_q.y_in;
    assign Rin       = out_q.r_in;
    assign OutPortin = out_q.outport_in;
    assign CONin     = out_q.con_in;
    assign GRA       = out_q.gra;
    assign GRB       = out_q.grb;
    assign GRC       = out_q.grc;
    assign IncPc     = out_q.inc_pc;
    assign read      = out_q.rd;
    assign write     = out_q.wr;
    assign mdr_read  = out_q.mdr_sel;
    assign control   = out_q.alu_op;
    assign run       = out_q.run;
    assign illegal   = out_q.illegal;

endmodule
